// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-programmable, maskable PAT_W-bit pattern.
// It supports overlapping and non-overlapping detection, gapped input and a saturating match counter.
module seq_detector_param #(
  parameter int                 PAT_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [PAT_W-1:0]   RST_PATTERN = 4'b1011,
  parameter logic [PAT_W-1:0]   RST_MASK    = '1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic [PAT_W-1:0] pattern_q,
  output logic [PAT_W-1:0] mask_q
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W:0]   FILL_NEED = (FILL_W + 1)'(PAT_W);

  logic [PAT_W-1:0]  hist_reg;
  logic [FILL_W-1:0] fill_reg;
  logic              dout_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [PAT_W-1:0]  pattern_reg;
  logic [PAT_W-1:0]  mask_reg;

  logic              accept;
  logic [PAT_W-1:0]  hist_next;
  logic [FILL_W-1:0] fill_next;
  logic [PAT_W-1:0]  miss;
  logic              fill_ok;
  logic              hit;

  // A cfg_load cycle swallows any concurrent input bit.
  assign accept    = din_valid & ~cfg_load;
  assign hist_next = {hist_reg[PAT_W-2:0], din};
  assign fill_ok   = ({1'b0, fill_reg} + 1'b1) >= FILL_NEED;

  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
    assign miss[gi] = mask_reg[gi] & (hist_next[gi] ^ pattern_reg[gi]);
  end

  assign hit = accept & fill_ok & (miss == '0);

  always_comb begin
    fill_next = fill_reg;
    if (hit && !overlap) begin
      fill_next = '0;
    end else if (fill_reg != FILL_FULL) begin
      fill_next = fill_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      hist_reg    <= '0;
      fill_reg    <= '0;
      dout_reg    <= 1'b0;
      cnt_reg     <= '0;
      pattern_reg <= RST_PATTERN;
      mask_reg    <= RST_MASK;
    end else begin
      dout_reg <= hit;
      if (cfg_load) begin
        pattern_reg <= cfg_pattern;
        mask_reg    <= cfg_mask;
        hist_reg    <= '0;
        fill_reg    <= '0;
      end else if (accept) begin
        hist_reg <= hist_next;
        fill_reg <= fill_next;
      end
      // Clear beats a coincident match; the counter never wraps.
      if (cnt_clr) begin
        cnt_reg <= '0;
      end else if (hit && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign dout      = dout_reg;
  assign match_cnt = cnt_reg;
  assign pattern_q = pattern_reg;
  assign mask_q    = mask_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: a window-based reference model queues expected
// outputs per stimulus cycle and an independent monitor compares them after each edge.
module tb_seq_detector_param;

  localparam int PW = 4;
  localparam int CW = 3;
  localparam logic [PW-1:0] RST_P = 4'b1011;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clr, din, din_valid, overlap, cfg_load, cnt_clr;
  logic [PW-1:0] cfg_pattern, cfg_mask;
  logic          dout;
  logic [CW-1:0] match_cnt;
  logic [PW-1:0] pattern_q, mask_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  seq_detector_param #(
    .PAT_W(PW), .CNT_W(CW), .RST_PATTERN(RST_P), .RST_MASK(4'hF)
  ) dut (
    .clk(clk), .clr(clr), .din(din), .din_valid(din_valid), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cnt_clr(cnt_clr), .dout(dout), .match_cnt(match_cnt),
    .pattern_q(pattern_q), .mask_q(mask_q)
  );

  typedef struct {
    int            due;
    logic          d;
    logic [CW-1:0] c;
    logic [PW-1:0] p;
    logic [PW-1:0] m;
  } exp_t;
  exp_t sbq[$];

  // Reference model: recent accepted bits (oldest first) plus bits counted toward the next match.
  int            win[$];
  int            mfill = 0;
  int            mcnt  = 0;
  logic [PW-1:0] mpat  = RST_P;
  logic [PW-1:0] mmask = 4'hF;

  task automatic step(input logic c, input logic v, input logic b, input logic ov,
                      input logic ld, input logic [PW-1:0] cp, input logic [PW-1:0] cm,
                      input logic cc);
    exp_t e;
    bit   hit;
    @(posedge clk);
    #1;
    clr = c; din_valid = v; din = b; overlap = ov;
    cfg_load = ld; cfg_pattern = cp; cfg_mask = cm; cnt_clr = cc;
    hit = 0;
    if (c) begin
      win.delete(); mfill = 0; mcnt = 0; mpat = RST_P; mmask = 4'hF;
    end else begin
      if (ld) begin
        mpat = cp; mmask = cm; win.delete(); mfill = 0;
      end else if (v) begin
        win.push_back(int'(b));
        if (win.size() > PW) void'(win.pop_front());
        mfill++;
        if (mfill >= PW) begin
          hit = 1;
          for (int j = 0; j < PW; j++)
            if (mmask[PW-1-j] && (win[j] != int'(mpat[PW-1-j]))) hit = 0;
        end
        if (hit && !ov) mfill = 0;
        if (mfill > PW) mfill = PW;
      end
      if (cc) mcnt = 0;
      else if (hit && mcnt < CNT_MAX) mcnt++;
    end
    e.due = cyc + 1; e.d = hit; e.c = CW'(mcnt); e.p = mpat; e.m = mmask;
    sbq.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, overlap, 0, '0, '0, 0);
  endtask

  task automatic bitin(input logic b, input logic ov);
    step(0, 1, b, ov, 0, '0, '0, 0);
  endtask

  task automatic load(input logic [PW-1:0] p, input logic [PW-1:0] m);
    step(0, 0, 0, overlap, 1, p, m, 1);
  endtask

  // Called only after an idle step, so extra edges carry no activity.
  task automatic chk_cnt(input string name, input int exp_cnt);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (match_cnt !== CW'(exp_cnt)) begin
      errors++;
      $display("FAIL %s: match_cnt got %0d expected %0d", name, match_cnt, exp_cnt);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      checks++;
      if (dout !== e.d || match_cnt !== e.c || pattern_q !== e.p || mask_q !== e.m) begin
        errors++;
        $display("FAIL sb cyc %0d: got dout=%b cnt=%0d pat=%b mask=%b expected dout=%b cnt=%0d pat=%b mask=%b",
                 cyc, dout, match_cnt, pattern_q, mask_q, e.d, e.c, e.p, e.m);
      end else begin
        $display("cyc %0d ok dout=%b cnt=%0d pat=%b mask=%b", cyc, dout, match_cnt, pattern_q, mask_q);
      end
    end
  end

  initial begin
    int s1[7] = '{1, 0, 1, 1, 0, 1, 1};
    int s3[12] = '{1, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 1};
    int s5[4] = '{1, 0, 1, 1};
    clr = 1; din = 0; din_valid = 0; overlap = 1; cfg_load = 0; cnt_clr = 0;
    cfg_pattern = '0; cfg_mask = '0;

    step(1, 0, 0, 1, 0, '0, '0, 0);
    idle();
    chk_cnt("reset_cnt", 0);

    // Overlapping detection of 1011.
    foreach (s1[i]) bitin(s1[i][0], 1);
    idle();
    chk_cnt("overlap_cnt", 2);

    // Same stream without overlap, then an extra 1.
    load(4'b1011, 4'hF);
    foreach (s1[i]) bitin(s1[i][0], 0);
    bitin(1, 0);
    idle();
    chk_cnt("nonoverlap_cnt", 1);

    // Masked pattern 1xx1.
    load(4'b1001, 4'b1001);
    foreach (s3[i]) bitin(s3[i][0], 1);
    idle();
    chk_cnt("masked_cnt", 1);

    // Zero mask saturates the counter, then a clear coincides with a match.
    load(4'b0000, 4'b0000);
    for (int i = 0; i < 12; i++) bitin(i[0], 1);
    idle();
    chk_cnt("saturate_cnt", CNT_MAX);
    step(0, 1, 1, 1, 0, '0, '0, 1);
    idle();
    chk_cnt("clr_wins_cnt", 0);

    // Gapped delivery of 1011.
    load(4'b1011, 4'hF);
    foreach (s5[i]) begin
      bitin(s5[i][0], 1);
      idle();
    end
    idle();
    chk_cnt("gapped_cnt", 1);

    // Reset mid-pattern, then cfg_load with a coincident valid bit.
    bitin(1, 1); bitin(0, 1); bitin(1, 1);
    step(1, 0, 0, 1, 0, '0, '0, 0);
    bitin(1, 1);
    step(0, 1, 1, 1, 1, 4'b1011, 4'hF, 0);
    bitin(0, 1); bitin(1, 1); bitin(1, 1);
    idle();
    chk_cnt("reset_mid_cnt", 0);

    // Randomized traffic with a small alphabet so matches are frequent.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 1)       step(1, 0, 0, 1, 0, '0, '0, 0);
      else if (r < 5)  step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 1,
                            PW'($urandom_range(0, 15)), PW'($urandom_range(0, 15)), $urandom_range(0, 1));
      else if (r < 8)  step(0, 1, $urandom_range(0, 1), $urandom_range(0, 1), 0, '0, '0, 1);
      else if (r < 25) idle();
      else             step(0, 1, $urandom_range(0, 1), $urandom_range(0, 1), 0, '0, '0, 0);
    end
    idle();

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
